ulpi_reg_ctrl: RTL

ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

---
 rtl/ulpi_pkg.sv | 36 +++
 rtl/ulpi_rxcmd_capture.sv | 49 ++++
 rtl/ulpi_reg_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
//   Shared ULPI definitions for the register-access link logic:
//     - TXCMD prefixes for register write / register read
//     - register-access FSM state encoding
//     - addresses of commonly used PHY registers
//     - helper that builds the TXCMD byte from a request
//   No ports (package).
// ---------------------------------------------------------------------------
package ulpi_pkg;

    // TXCMD byte = {prefix, 6-bit immediate register address}
    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    // PHY register addresses
    localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
    localparam logic [5:0] ADDR_IFC_CTRL  = 6'h07;
    localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TXCMD,
        ST_WDATA,
        ST_STOP,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_RD_END,
        ST_DIR_WAIT
    } ulpi_state_t;

    function automatic logic [7:0] txcmd_byte(input logic write, input logic [5:0] addr);
        return {(write ? TXCMD_REGW : TXCMD_REGR), addr};
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_capture.sv
// ---------------------------------------------------------------------------
// ulpi_rxcmd_capture
//   Tracks the registered bus direction and captures RX CMD bytes sent by the
//   PHY while it owns the bus outside a register read.
//
//   Ports:
//     clk          in   ULPI clock, rising edge
//     nrst         in   synchronous active-low reset
//     dir          in   ULPI_DIR (1 = PHY owns the bus)
//     nxt          in   ULPI_NXT
//     data         in   ULPI_DATA from the PHY
//     rd_phase     in   1 while the FSM owns the inbound bus for a reg read
//     rxcmd_valid  out  one-cycle pulse, registered, one cycle after the byte
//     rxcmd        out  last captured RX CMD byte (held)
// ---------------------------------------------------------------------------
module ulpi_rxcmd_capture (
    input  logic       clk,
    input  logic       nrst,
    input  logic       dir,
    input  logic       nxt,
    input  logic [7:0] data,
    input  logic       rd_phase,
    output logic       rxcmd_valid,
    output logic [7:0] rxcmd
);

    logic dir_q;
    logic take;

    // The first cycle with dir=1 is bus turnaround (dir_q still 0): the data
    // lines are not yet driven by the PHY, so nothing is sampled there.
    // Bytes with nxt=1 are USB receive data, not RX CMDs.
    assign take = dir && dir_q && !nxt && !rd_phase;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            dir_q       <= 1'b0;
            rxcmd_valid <= 1'b0;
            rxcmd       <= 8'h00;
        end else begin
            dir_q       <= dir;
            rxcmd_valid <= take;
            if (take) begin
                rxcmd <= data;
            end
        end
    end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// ulpi_reg_ctrl
//   ULPI link-side register access controller. Accepts one register
//   read/write request at a time, runs the ULPI TXCMD / data / STP sequence,
//   and reports completion with a one-cycle response pulse. RX CMD bytes seen
//   while the PHY owns the bus are captured by ulpi_rxcmd_capture.
//
//   Parameter:
//     TIMEOUT_CYCLES  cycles to wait for ULPI_NXT (or DIR in read turnaround)
//                     per phase before aborting with an error (>= 1)
//
//   Ports:
//     CLK, NRST                  ULPI 60 MHz clock, sync active-low reset
//     ULPI_DATA_I/_O/_OE         ULPI data bus split into in/out/enable
//     ULPI_DIR, ULPI_NXT         PHY direction and throttle
//     ULPI_STP                   link stop strobe
//     REQ_VALID/READY/WRITE/ADDR/WDATA   request handshake
//     RSP_VALID/RDATA/ERR        completion pulse, read data, timeout flag
//     RXCMD_VALID, RXCMD         RX CMD capture pulse and held byte
// ---------------------------------------------------------------------------
module ulpi_reg_ctrl
    import ulpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    output logic       ULPI_DATA_OE,
    input  logic       ULPI_DIR,
    input  logic       ULPI_NXT,
    output logic       ULPI_STP,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WRITE,
    input  logic [5:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_ERR,
    output logic       RXCMD_VALID,
    output logic [7:0] RXCMD
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    ulpi_state_t   state;

    // request latched at acceptance so a DIR abort can replay it
    logic          wr_q;
    logic [5:0]    addr_q;
    logic [7:0]    wdata_q;

    logic [CW-1:0] cnt;
    logic          timeout;

    logic [7:0]    data_q;
    logic          oe_q;
    logic          stp_q;
    logic          err_q;      // STOP was entered because of a timeout
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [7:0]    rdata_q;
    logic          ready_en;   // keeps READY low in the cycle after reset

    logic          rd_phase;

    // Last waiting cycle of a phase: this cycle is the TIMEOUT_CYCLES-th.
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // DIR=1 means the PHY is driving: release the bus in the very same cycle,
    // independent of the registered enable.
    assign ULPI_DATA_OE = oe_q && !ULPI_DIR;
    assign ULPI_DATA_O  = ULPI_DATA_OE ? data_q : 8'h00;
    assign ULPI_STP     = stp_q;

    assign REQ_READY    = ready_en && (state == ST_IDLE) && !ULPI_DIR;

    assign RSP_VALID    = rsp_valid_q;
    assign RSP_ERR      = rsp_err_q;
    assign RSP_RDATA    = rdata_q;

    assign rd_phase     = (state == ST_RD_TURN) || (state == ST_RD_DATA);

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state       <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 8'h00;
            cnt         <= '0;
            data_q      <= 8'h00;
            oe_q        <= 1'b0;
            stp_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
            ready_en    <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            stp_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        wr_q    <= REQ_WRITE;
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        data_q  <= txcmd_byte(REQ_WRITE, REQ_ADDR);
                        oe_q    <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_TXCMD;
                    end
                end

                ST_TXCMD: begin
                    if (ULPI_DIR) begin
                        // PHY took the bus: abandon silently, replay later
                        oe_q   <= 1'b0;
                        data_q <= 8'h00;
                        cnt    <= '0;
                        state  <= ST_DIR_WAIT;
                    end else if (ULPI_NXT) begin
                        cnt <= '0;
                        if (wr_q) begin
                            data_q <= wdata_q;
                            state  <= ST_WDATA;
                        end else begin
                            oe_q   <= 1'b0;
                            data_q <= 8'h00;
                            state  <= ST_RD_TURN;
                        end
                    end else if (timeout) begin
                        data_q <= 8'h00;
                        stp_q  <= 1'b1;
                        err_q  <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WDATA: begin
                    if (ULPI_DIR) begin
                        oe_q   <= 1'b0;
                        data_q <= 8'h00;
                        cnt    <= '0;
                        state  <= ST_DIR_WAIT;
                    end else if (ULPI_NXT || timeout) begin
                        data_q <= 8'h00;
                        stp_q  <= 1'b1;
                        err_q  <= !ULPI_NXT;
                        cnt    <= '0;
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    oe_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    err_q       <= 1'b0;
                    state       <= ST_IDLE;
                end

                ST_RD_TURN: begin
                    if (ULPI_DIR) begin
                        // this is the turnaround cycle; data comes next
                        cnt   <= '0;
                        state <= ST_RD_DATA;
                    end else if (timeout) begin
                        // link drives the idle byte alongside STP
                        oe_q   <= 1'b1;
                        data_q <= 8'h00;
                        stp_q  <= 1'b1;
                        err_q  <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RD_DATA: begin
                    rdata_q <= ULPI_DATA_I;
                    state   <= ST_RD_END;
                end

                ST_RD_END: begin
                    if (!ULPI_DIR) begin
                        rsp_valid_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                ST_DIR_WAIT: begin
                    if (!ULPI_DIR) begin
                        data_q <= txcmd_byte(wr_q, addr_q);
                        oe_q   <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_TXCMD;
                    end
                end

                default: begin
                    oe_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ulpi_rxcmd_capture u_rxcmd (
        .clk         (CLK),
        .nrst        (NRST),
        .dir         (ULPI_DIR),
        .nxt         (ULPI_NXT),
        .data        (ULPI_DATA_I),
        .rd_phase    (rd_phase),
        .rxcmd_valid (RXCMD_VALID),
        .rxcmd       (RXCMD)
    );

endmodule
